axi4_lite_clint: RTL and testbench
==================================

AXI4_LITE_CLINT -- requirements
Module: axi4_lite_clint

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0200_0000, giving the base of the 64 KiB register window.
REQ-002 SHALL have parameter TICK_DIV, default 1, giving the clk cycles per mtime increment (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports araddr input 32, arvalid input 1, arready output 1, forming the AXI4-Lite read-address channel.
REQ-006 SHALL have ports rdata output 32, rresp output 2, rvalid output 1, rready input 1, forming the read-data channel.
REQ-007 SHALL have ports awaddr input 32, awvalid input 1, awready output 1, forming the write-address channel.
REQ-008 SHALL have ports wdata input 32, wstrb input 4, wvalid input 1, wready output 1, forming the write-data channel.
REQ-009 SHALL have ports bresp output 2, bvalid output 1, bready input 1, forming the write-response channel.
REQ-010 SHALL have port timer_irq  output  1  machine timer interrupt, level-sensitive.

Function
REQ-011 Register map, offsets from BASE_ADDR: 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32], 0xBFF8 mtime[31:0], 0xBFFC mtime[63:32]; all read/write.
REQ-012 Address decode SHALL use araddr/awaddr[31:16]==BASE_ADDR[31:16] plus an exact match of [15:2] against the map; [1:0] ignored.
REQ-013 Any other address SHALL be unmapped: a read returns rdata 0 with rresp SLVERR (2'b10); a write has no effect and returns bresp SLVERR.
REQ-014 Mapped accesses SHALL respond OKAY (2'b00).
REQ-015 Prescaler: a 16-bit counter SHALL count 0..TICK_DIV-1 and wrap; mtime SHALL increment by 1 in the cycle the counter wraps (every cycle when TICK_DIV=1).
REQ-016 mtime SHALL wrap from 2^64-1 to 0 without any flag.
REQ-017 timer_irq SHALL be registered and equal (mtime >= mtimecmp) as an unsigned 64-bit compare, evaluated on the previous cycle's register values.
REQ-018 Read channel states: R_IDLE, R_RESP. arready=1 only in R_IDLE.
REQ-019 On the AR handshake, the block SHALL capture the decoded register value (mtime as of that cycle, pre-increment) into rdata and enter R_RESP with rvalid=1 next cycle; read latency is 1 cycle.
REQ-020 In R_RESP, rdata/rresp/rvalid SHALL hold stable until rready=1, then return to R_IDLE; back-to-back reads therefore cost 2 cycles each.
REQ-021 Write channel states: W_IDLE, W_RESP. awready=wready=1 only in W_IDLE with awvalid&wvalid both high; AW and W SHALL be accepted in the same cycle, never alone.
REQ-022 On the write handshake, each byte i with wstrb[i]=1 SHALL update in that same edge; bvalid=1 next cycle, held with bresp until bready=1.
REQ-023 A write to mtime coinciding with a prescaler wrap SHALL win: written bytes take wdata; unwritten bytes take the incremented value.
REQ-024 Read and write channels are independent; a read and a write to the same register handshaking in the same cycle SHALL return the old value.
REQ-025 The prescaler SHALL NOT be reset by writes to mtime.

Reset
REQ-026 On rst: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, timer_irq=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, both FSMs idle (arready=1).
REQ-027 rst asserted mid-transaction SHALL drop any pending rvalid/bvalid; a write handshaking in the same cycle as rst SHALL be discarded.

Verification
REQ-028 TICK_DIV=1, reset then read 0xBFF8 with AR at cycle 10 after reset release -> rvalid next cycle, rdata=10, rresp OKAY.
REQ-029 Write mtimecmp lo=20, hi=0 -> timer_irq rises once mtime reaches 20 (one cycle after the compare becomes true); rewrite mtimecmp hi=1 -> irq clears.
REQ-030 Write 0xBFF8 wstrb=4'b0001 wdata=0xAB while mtime=0x1234 -> mtime low byte becomes 0xAB, upper bytes keep counting; bresp OKAY.
REQ-031 Read 0x0000_1000 inside the window and write BASE_ADDR+0x8 -> rresp=SLVERR, rdata=0, bresp=SLVERR, no register changes.
REQ-032 Hold rready=0 for 5 cycles after AR -> rvalid and rdata stable, arready=0 throughout; AW/W with bready=0 -> bvalid held, wready=0 for a second write.
REQ-033 Set mtime=64'hFFFF_FFFF_FFFF_FFFF, TICK_DIV=3 -> mtime reads 0 after exactly 3 cycles; assert rst while bvalid=1 -> bvalid=0 the next cycle.

Source files
------------

// File: rtl/axi4_lite_clint_if.sv
// AXI4-Lite bus bundle for the CLINT timer block: AR/R/AW/W/B channels.
interface axi4_lite_clint_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi4_lite_clint.sv
// CLINT machine timer: prescaled 64-bit mtime, mtimecmp and a registered
// timer interrupt, exposed through independent AXI4-Lite read/write channels.
module axi4_lite_clint #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic             clk,
    input  logic             rst,
    axi4_lite_clint_if.slave bus,
    output logic             timer_irq
);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [15:0] DIV_LAST    = 16'(TICK_DIV - 1);

    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [1:0] {SEL_CMP_LO, SEL_CMP_HI, SEL_TIME_LO, SEL_TIME_HI} sel_t;

    r_state_t    r_state_q, r_state_d;
    w_state_t    w_state_q, w_state_d;
    logic [63:0] mtime_q, mtime_d, mtime_inc;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [15:0] presc_q, presc_d;
    logic        presc_wrap;
    logic        irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d, rd_val;
    logic [1:0]  rresp_q, rresp_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rd_hit, wr_hit, w_fire;
    sel_t        rd_sel, wr_sel;

    function automatic logic decode(input logic [31:0] addr, output sel_t sel);
        logic hit;
        sel = SEL_CMP_LO;
        hit = 1'b0;
        if (addr[31:16] == BASE_ADDR[31:16]) begin
            hit = 1'b1;
            case (addr[15:2])
                14'h1000: sel = SEL_CMP_LO;
                14'h1001: sel = SEL_CMP_HI;
                14'h2FFE: sel = SEL_TIME_LO;
                14'h2FFF: sel = SEL_TIME_HI;
                default:  hit = 1'b0;
            endcase
        end
        return hit;
    endfunction

    always_comb begin
        rd_hit = decode(bus.araddr, rd_sel);
        wr_hit = decode(bus.awaddr, wr_sel);
        case (rd_sel)
            SEL_CMP_LO:  rd_val = mtimecmp_q[31:0];
            SEL_CMP_HI:  rd_val = mtimecmp_q[63:32];
            SEL_TIME_LO: rd_val = mtime_q[31:0];
            default:     rd_val = mtime_q[63:32];
        endcase
    end

    always_comb begin
        presc_wrap = (presc_q == DIV_LAST);
        presc_d    = presc_wrap ? '0 : presc_q + 16'd1;
        mtime_inc  = mtime_q + {63'd0, presc_wrap};
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        irq_d      = (mtime_q >= mtimecmp_q);
        r_state_d  = r_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        w_state_d  = w_state_q;
        bresp_d    = bresp_q;
        w_fire     = (w_state_q == W_IDLE) && bus.awvalid && bus.wvalid;

        // Reads sample the pre-edge registers, so a same-cycle write is not visible.
        case (r_state_q)
            R_IDLE: begin
                if (bus.arvalid) begin
                    r_state_d = R_RESP;
                    rdata_d   = rd_hit ? rd_val : '0;
                    rresp_d   = rd_hit ? RESP_OKAY : RESP_SLVERR;
                end
            end
            default: begin
                if (bus.rready) r_state_d = R_IDLE;
            end
        endcase

        // Written bytes override the incremented mtime; the rest keep counting.
        case (w_state_q)
            W_IDLE: begin
                if (w_fire) begin
                    w_state_d = W_RESP;
                    bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
                    if (wr_hit) begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            if (bus.wstrb[i]) begin
                                case (wr_sel)
                                    SEL_CMP_LO:  mtimecmp_d[8*i +: 8]      = bus.wdata[8*i +: 8];
                                    SEL_CMP_HI:  mtimecmp_d[32 + 8*i +: 8] = bus.wdata[8*i +: 8];
                                    SEL_TIME_LO: mtime_d[8*i +: 8]         = bus.wdata[8*i +: 8];
                                    default:     mtime_d[32 + 8*i +: 8]    = bus.wdata[8*i +: 8];
                                endcase
                            end
                        end
                    end
                end
            end
            default: begin
                if (bus.bready) w_state_d = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= R_IDLE;
            w_state_q  <= W_IDLE;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            presc_q    <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            bresp_q    <= '0;
        end else begin
            r_state_q  <= r_state_d;
            w_state_q  <= w_state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            presc_q    <= presc_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            bresp_q    <= bresp_d;
        end
    end

    assign bus.arready = (r_state_q == R_IDLE);
    assign bus.rvalid  = (r_state_q == R_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.awready = w_fire;
    assign bus.wready  = w_fire;
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.bresp   = bresp_q;
    assign timer_irq   = irq_q;
endmodule

// File: tb/tb_axi4_lite_clint.sv
// Bench for axi4_lite_clint: two instances (TICK_DIV 1 and 3) share one stimulus
// stream and are checked against a register-level reference model.
module tb_axi4_lite_clint;
    localparam logic [31:0] BASE      = 32'h0200_0000;
    localparam logic [31:0] A_CMP_LO  = BASE + 32'h4000;
    localparam logic [31:0] A_CMP_HI  = BASE + 32'h4004;
    localparam logic [31:0] A_TIME_LO = BASE + 32'hBFF8;
    localparam logic [31:0] A_TIME_HI = BASE + 32'hBFFC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic        arvalid = 1'b0, rready = 1'b1, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
    logic [3:0]  wstrb = '0;
    logic        irq1, irq3;

    axi4_lite_clint_if bus1 ();
    axi4_lite_clint_if bus3 ();

    assign bus1.araddr = araddr;  assign bus3.araddr = araddr;
    assign bus1.arvalid = arvalid; assign bus3.arvalid = arvalid;
    assign bus1.rready = rready;  assign bus3.rready = rready;
    assign bus1.awaddr = awaddr;  assign bus3.awaddr = awaddr;
    assign bus1.awvalid = awvalid; assign bus3.awvalid = awvalid;
    assign bus1.wdata = wdata;    assign bus3.wdata = wdata;
    assign bus1.wstrb = wstrb;    assign bus3.wstrb = wstrb;
    assign bus1.wvalid = wvalid;  assign bus3.wvalid = wvalid;
    assign bus1.bready = bready;  assign bus3.bready = bready;

    axi4_lite_clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .timer_irq(irq1));
    axi4_lite_clint #(.BASE_ADDR(BASE), .TICK_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .timer_irq(irq3));

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // ---------------- reference model ----------------
    logic [63:0] m1, m3, cmp_m;
    logic [31:0] e_rdata1, e_rdata3;
    logic [1:0]  e_rresp, e_bresp;
    logic        e_irq1, e_irq3, rbusy, wbusy;
    int unsigned cnt;
    logic        mdl_rfire, mdl_wfire;

    assign mdl_rfire = arvalid && !rbusy;
    assign mdl_wfire = awvalid && wvalid && !wbusy;

    // 0 cmp lo, 1 cmp hi, 2 time lo, 3 time hi, -1 unmapped
    function automatic int slot(input logic [31:0] a);
        logic [31:0] off;
        if ((a & 32'hFFFF_0000) != (BASE & 32'hFFFF_0000)) return -1;
        off = a & 32'h0000_FFFC;
        case (off)
            32'h4000: return 0;
            32'h4004: return 1;
            32'hBFF8: return 2;
            32'hBFFC: return 3;
            default:  return -1;
        endcase
    endfunction

    function automatic bit tick(input int unsigned c, input int unsigned td);
        return (c % td) == td - 1;
    endfunction

    function automatic logic [31:0] rd_val(input logic [31:0] a, input logic [63:0] t, input logic [63:0] c);
        case (slot(a))
            0: return c[31:0];
            1: return c[63:32];
            2: return t[31:0];
            3: return t[63:32];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [63:0] next_val(input logic [63:0] cur, input bit is_time, input bit counts,
                                             input bit wr, input logic [31:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
        logic [63:0] r;
        int sl;
        r = counts ? cur + 64'd1 : cur;
        sl = slot(a);
        if (wr && sl >= 0 && ((sl >= 2) == is_time)) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) r[(sl[0] ? 32 : 0) + 8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m1 <= '0; m3 <= '0; cmp_m <= '1; cnt <= 0;
            rbusy <= 1'b0; wbusy <= 1'b0;
            e_rdata1 <= '0; e_rdata3 <= '0; e_rresp <= '0; e_bresp <= '0;
            e_irq1 <= 1'b0; e_irq3 <= 1'b0;
        end else begin
            cnt    <= cnt + 1;
            e_irq1 <= (m1 >= cmp_m);
            e_irq3 <= (m3 >= cmp_m);
            if (mdl_rfire) begin
                rbusy    <= 1'b1;
                e_rdata1 <= rd_val(araddr, m1, cmp_m);
                e_rdata3 <= rd_val(araddr, m3, cmp_m);
                e_rresp  <= (slot(araddr) >= 0) ? 2'b00 : 2'b10;
            end else if (rbusy && rready) begin
                rbusy <= 1'b0;
            end
            if (mdl_wfire) begin
                wbusy   <= 1'b1;
                e_bresp <= (slot(awaddr) >= 0) ? 2'b00 : 2'b10;
            end else if (wbusy && bready) begin
                wbusy <= 1'b0;
            end
            m1    <= next_val(m1, 1'b1, tick(cnt, 1), mdl_wfire, awaddr, wdata, wstrb);
            m3    <= next_val(m3, 1'b1, tick(cnt, 3), mdl_wfire, awaddr, wdata, wstrb);
            cmp_m <= next_val(cmp_m, 1'b0, 1'b0, mdl_wfire, awaddr, wdata, wstrb);
        end
    end

    // ---------------- drivers (all start and end on a falling edge) ----------------
    task automatic do_reset();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1; bready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output bit ok);
        int unsigned n = 0;
        araddr = a; arvalid = 1'b1;
        while (!bus1.arready && n < 50) begin @(negedge clk); n++; end
        ok = bus1.arready;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL rd_timeout addr=%h arready got 0 expected 1", a);
        end else begin
            @(negedge clk);
        end
        arvalid = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output bit ok);
        int unsigned n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        while (!bus1.awready && n < 50) begin @(negedge clk); #1; n++; end
        ok = bus1.awready;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL wr_timeout addr=%h awready got 0 expected 1", a);
        end else begin
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus1.arready, bus1.rvalid, bus1.bvalid, bus1.awready, irq1, bus1.rresp, bus1.bresp} !== 9'b1_0000_0000) begin
            n_bad++;
            $display("FAIL reset_flags1 got=%b expected=100000000",
                     {bus1.arready, bus1.rvalid, bus1.bvalid, bus1.awready, irq1, bus1.rresp, bus1.bresp});
        end
        n_cmp++;
        if ({bus3.arready, bus3.rvalid, bus3.bvalid, bus3.awready, irq3, bus3.rresp, bus3.bresp} !== 9'b1_0000_0000) begin
            n_bad++;
            $display("FAIL reset_flags3 got=%b expected=100000000",
                     {bus3.arready, bus3.rvalid, bus3.bvalid, bus3.awready, irq3, bus3.rresp, bus3.bresp});
        end
        n_cmp++;
        if (bus1.rdata !== 32'd0 || bus3.rdata !== 32'd0) begin
            n_bad++; $display("FAIL reset_rdata got=%h/%h expected 0", bus1.rdata, bus3.rdata);
        end
    endtask

    task automatic test_read_latency();
        bit ok;
        do_reset();
        repeat (10) @(negedge clk);
        bus_read(A_TIME_LO, ok);
        if (ok) begin
            n_cmp++;
            if (bus1.rvalid !== 1'b1 || bus1.rresp !== 2'b00) begin
                n_bad++; $display("FAIL lat_valid got rvalid=%b rresp=%b expected 1/00", bus1.rvalid, bus1.rresp);
            end
            n_cmp++;
            if (bus1.rdata !== 32'd10) begin
                n_bad++; $display("FAIL lat_rdata1 got=%0d expected=10", bus1.rdata);
            end
            n_cmp++;
            if (bus3.rdata !== e_rdata3) begin
                n_bad++; $display("FAIL lat_rdata3 got=%0d expected=%0d", bus3.rdata, e_rdata3);
            end
        end
    endtask

    task automatic test_irq();
        bit ok;
        do_reset();
        bus_write(A_CMP_LO, 32'd20, 4'hF, ok);
        bus_write(A_CMP_HI, 32'd0, 4'hF, ok);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_cmp++;
            if (irq1 !== e_irq1 || irq3 !== e_irq3) begin
                n_bad++; $display("FAIL irq_track cyc=%0d got=%b%b expected=%b%b", i, irq1, irq3, e_irq1, e_irq3);
            end
        end
        n_cmp++;
        if (irq1 !== 1'b1) begin n_bad++; $display("FAIL irq_raised got=%b expected=1", irq1); end
        bus_write(A_CMP_HI, 32'd1, 4'hF, ok);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (irq1 !== 1'b0 || irq3 !== 1'b0) begin
            n_bad++; $display("FAIL irq_cleared got=%b%b expected=00", irq1, irq3);
        end
    endtask

    task automatic test_strobe();
        bit ok;
        do_reset();
        bus_write(A_TIME_HI, 32'd0, 4'hF, ok);
        bus_write(A_TIME_LO, 32'h1234, 4'hF, ok);
        bus_write(A_TIME_LO, 32'hAB, 4'b0001, ok);
        n_cmp++;
        if (bus1.bvalid !== 1'b1 || bus1.bresp !== 2'b00) begin
            n_bad++; $display("FAIL strb_bresp got bvalid=%b bresp=%b expected 1/00", bus1.bvalid, bus1.bresp);
        end
        bus_read(A_TIME_LO, ok);
        n_cmp++;
        if (bus1.rdata !== 32'h0000_12AB) begin
            n_bad++; $display("FAIL strb_lo1 got=%h expected=000012ab", bus1.rdata);
        end
        n_cmp++;
        if (bus3.rdata !== e_rdata3) begin
            n_bad++; $display("FAIL strb_lo3 got=%h expected=%h", bus3.rdata, e_rdata3);
        end
    endtask

    task automatic test_unmapped();
        bit ok;
        logic [31:0] addrs [4];
        do_reset();
        bus_write(A_CMP_LO, 32'h0000_55AA, 4'hF, ok);
        bus_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, ok);
        n_cmp++;
        if (bus1.bresp !== 2'b10 || bus3.bresp !== 2'b10) begin
            n_bad++; $display("FAIL unm_bresp got=%b/%b expected=10", bus1.bresp, bus3.bresp);
        end
        addrs = '{BASE + 32'h1000, 32'h0300_4000, A_CMP_LO + 32'd3, A_CMP_HI};
        for (int i = 0; i < 4; i++) begin
            bus_read(addrs[i], ok);
            n_cmp++;
            if (bus1.rdata !== e_rdata1 || bus3.rdata !== e_rdata3 || bus1.rresp !== e_rresp) begin
                n_bad++;
                $display("FAIL unm_read addr=%h got=%h/%h resp=%b expected=%h/%h resp=%b",
                         addrs[i], bus1.rdata, bus3.rdata, bus1.rresp, e_rdata1, e_rdata3, e_rresp);
            end
        end
    endtask

    task automatic test_concurrent();
        bit ok;
        bus_write(A_CMP_LO, 32'hCAFE_0001, 4'hF, ok);
        @(negedge clk);
        araddr = A_CMP_LO; awaddr = A_CMP_LO; wdata = 32'h77; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n_cmp++;
        if (bus1.arready !== 1'b1 || bus1.awready !== 1'b1) begin
            n_bad++; $display("FAIL conc_ready got ar=%b aw=%b expected 1/1", bus1.arready, bus1.awready);
        end
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        n_cmp++;
        if (bus1.rdata !== 32'hCAFE_0001 || bus1.rvalid !== 1'b1 || bus1.bvalid !== 1'b1) begin
            n_bad++; $display("FAIL conc_old got=%h rv=%b bv=%b expected=cafe0001 1 1", bus1.rdata, bus1.rvalid, bus1.bvalid);
        end
        @(negedge clk);
        bus_read(A_CMP_LO, ok);
        n_cmp++;
        if (bus1.rdata !== 32'h77 || bus3.rdata !== 32'h77) begin
            n_bad++; $display("FAIL conc_new got=%h/%h expected=00000077", bus1.rdata, bus3.rdata);
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] cap1, cap3;
        do_reset();
        rready = 1'b0;
        bus_read(A_TIME_LO, ok);
        cap1 = bus1.rdata; cap3 = bus3.rdata;
        n_cmp++;
        if (cap1 !== e_rdata1 || cap3 !== e_rdata3) begin
            n_bad++; $display("FAIL stall_first got=%h/%h expected=%h/%h", cap1, cap3, e_rdata1, e_rdata3);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus1.rvalid !== 1'b1 || bus1.arready !== 1'b0 || bus1.rdata !== cap1 || bus3.rdata !== cap3) begin
                n_bad++;
                $display("FAIL stall_hold cyc=%0d got rv=%b ar=%b d=%h/%h expected 1 0 %h/%h",
                         i, bus1.rvalid, bus1.arready, bus1.rdata, bus3.rdata, cap1, cap3);
            end
        end
        rready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus1.rvalid !== 1'b0 || bus1.arready !== 1'b1) begin
            n_bad++; $display("FAIL stall_release got rv=%b ar=%b expected 0 1", bus1.rvalid, bus1.arready);
        end
        bready = 1'b0;
        bus_write(A_CMP_HI, 32'd5, 4'hF, ok);
        awaddr = A_CMP_HI; wdata = 32'd9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (bus1.bvalid !== 1'b1 || bus1.wready !== 1'b0 || bus1.awready !== 1'b0) begin
                n_bad++; $display("FAIL bstall_hold cyc=%0d got bv=%b wr=%b aw=%b expected 1 0 0",
                                  i, bus1.bvalid, bus1.wready, bus1.awready);
            end
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        bus_write(A_CMP_HI, 32'd9, 4'hF, ok);
        bus_read(A_CMP_HI, ok);
        n_cmp++;
        if (bus1.rdata !== 32'd9 || e_rdata1 !== 32'd9) begin
            n_bad++; $display("FAIL bstall_data got=%0d model=%0d expected=9", bus1.rdata, e_rdata1);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        bus_write(A_TIME_HI, 32'hFFFF_FFFF, 4'hF, ok);
        bus_write(A_TIME_LO, 32'hFFFF_FFFF, 4'hF, ok);
        bus_read(A_TIME_LO, ok);
        n_cmp++;
        if (bus1.rdata !== 32'hFFFF_FFFF || bus3.rdata !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL wrap_pre got=%h/%h expected=ffffffff", bus1.rdata, bus3.rdata);
        end
        bus_read(A_TIME_HI, ok);
        n_cmp++;
        if (bus1.rdata !== 32'd0 || bus3.rdata !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL wrap_hi got=%h/%h expected=00000000/ffffffff", bus1.rdata, bus3.rdata);
        end
        bus_read(A_TIME_LO, ok);
        n_cmp++;
        if (bus1.rdata !== 32'd3 || bus3.rdata !== 32'd0 || bus3.rdata !== e_rdata3) begin
            n_bad++; $display("FAIL wrap_post got=%h/%h expected=00000003/00000000", bus1.rdata, bus3.rdata);
        end
        bready = 1'b0;
        bus_write(A_CMP_LO, 32'd1, 4'hF, ok);
        awaddr = A_TIME_LO; wdata = 32'h5555_5555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus1.bvalid !== 1'b0 || bus3.bvalid !== 1'b0 || bus1.rvalid !== 1'b0) begin
            n_bad++; $display("FAIL rst_drop got bv=%b/%b rv=%b expected 0", bus1.bvalid, bus3.bvalid, bus1.rvalid);
        end
        rst = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        bus_read(A_TIME_LO, ok);
        n_cmp++;
        if (bus1.rdata !== 32'd0 || bus3.rdata !== 32'd0) begin
            n_bad++; $display("FAIL rst_discard got=%h/%h expected=0", bus1.rdata, bus3.rdata);
        end
        bus_read(A_CMP_LO, ok);
        n_cmp++;
        if (bus1.rdata !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL rst_cmp got=%h expected=ffffffff", bus1.rdata);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] atab [6];
        logic [31:0] a, d;
        int unsigned op;
        atab = '{A_CMP_LO, A_CMP_HI, A_TIME_LO, A_TIME_HI, BASE + 32'h0100, 32'h1000_BFF8};
        do_reset();
        for (int it = 0; it < 80; it++) begin
            a  = atab[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
            op = $urandom_range(0, 2);
            if (op == 0) begin
                bus_read(a, ok);
                n_cmp++;
                if (bus1.rvalid !== 1'b1 || bus1.rdata !== e_rdata1 || bus3.rdata !== e_rdata3 ||
                    bus1.rresp !== e_rresp || bus3.rresp !== e_rresp) begin
                    n_bad++;
                    $display("FAIL rnd_read it=%0d addr=%h got=%h/%h resp=%b expected=%h/%h resp=%b",
                             it, a, bus1.rdata, bus3.rdata, bus1.rresp, e_rdata1, e_rdata3, e_rresp);
                end
            end else if (op == 1) begin
                d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 300));
                bus_write(a, d, 4'($urandom_range(0, 15)), ok);
                n_cmp++;
                if (bus1.bvalid !== 1'b1 || bus1.bresp !== e_bresp || bus3.bresp !== e_bresp) begin
                    n_bad++;
                    $display("FAIL rnd_write it=%0d addr=%h got bv=%b bresp=%b/%b expected 1 %b",
                             it, a, bus1.bvalid, bus1.bresp, bus3.bresp, e_bresp);
                end
            end else begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
            n_cmp++;
            if (irq1 !== e_irq1 || irq3 !== e_irq3) begin
                n_bad++; $display("FAIL rnd_irq it=%0d got=%b%b expected=%b%b", it, irq1, irq3, e_irq1, e_irq3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_irq();
        test_strobe();
        test_unmapped();
        test_concurrent();
        test_stall();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
